agu_addr_stage: RTL and testbench

- Stage directly downstream of the AGU reservation station.
- Accepts the single issued memory op per cycle (physical source Pa, 5-bit Imm, ROB tag).
- Reads the base operand from the physical register file and computes the effective address base + zero-extended Imm.
- Buffers results in a small in-order FIFO feeding the load/store unit over a valid/ready handshake; drives freeze_back to the RS so the buffer never overflows.

---
 rtl/core_pkg.sv | 14 +
 rtl/agu_fifo.sv | 82 ++++++++
 rtl/agu_addr_stage.sv | 105 ++++++++++
 tb/tb_agu_addr_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types and widths for the AGU address stage and its neighbours.
package core_pkg;

  localparam int PREG_W     = 5;
  localparam int IMM_W      = 5;
  localparam int TAG_W      = 5;
  localparam int AGU_ADDR_W = 32;

  typedef struct packed {
    logic [AGU_ADDR_W-1:0] addr;
    logic [TAG_W-1:0]      tag_ROB;
  } agu_entry_t;

endpackage

// File: rtl/agu_fifo.sv
// In-order address FIFO between the AGU and the LSU, with head outputs held in registers.
module agu_fifo
  import core_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = agu_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  entry_t                   push_data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output entry_t                   head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  entry_t             head_q, head_d;
  logic               do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && valid_q && !flush_i;
    do_push  = push_i && !flush_i;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    valid_d = (count_d != '0);
    head_d  = '0;
    // The next head is the slot being written right now when the queue was empty after the pop.
    if (valid_d) begin
      if (do_push && (rd_ptr_d == wr_ptr_q)) head_d = push_data_i;
      else                                   head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign valid_o = valid_q;
  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/agu_addr_stage.sv
// AGU address stage: PRF base + zero-extended immediate, one register stage, then an
// in-order FIFO to the LSU with conservative back-pressure to the reservation station.
module agu_addr_stage
  import core_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    valid_op_awake,
  input  logic [PREG_W-1:0]       Pa_awake,
  input  logic [IMM_W-1:0]        Imm_awake,
  input  logic [TAG_W-1:0]        tag_ROB_awake,
  output logic [PREG_W-1:0]       rd_addr_prf,
  input  logic [DATA_W-1:0]       rd_data_prf,
  output logic                    freeze_back,
  output logic                    valid_agu,
  output logic [ADDR_W-1:0]       addr_agu,
  output logic [TAG_W-1:0]        tag_ROB_agu,
  input  logic                    ready_lsu,
  output logic [$clog2(DEPTH):0]  count_agu
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag_ROB;
  } entry_t;

  logic [ADDR_W-1:0] base_s0;
  logic [ADDR_W-1:0] addr_s0;
  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  logic [SUM_W-1:0]  occ_sum;
  entry_t            push_entry;
  entry_t            head_entry;

  assign rd_addr_prf = Pa_awake;

  generate
    if (DATA_W >= ADDR_W) begin : g_base_trunc
      assign base_s0 = rd_data_prf[ADDR_W-1:0];
    end else begin : g_base_zext
      assign base_s0 = {{(ADDR_W-DATA_W){1'b0}}, rd_data_prf};
    end
  endgenerate

  // S0: effective address, carry out of ADDR_W silently dropped
  assign addr_s0 = base_s0 + ADDR_W'(Imm_awake);

  always_comb begin
    s1_valid_d = valid_op_awake && !flush;
    s1_addr_d  = s1_addr_q;
    s1_tag_d   = s1_tag_q;
    if (valid_op_awake) begin
      s1_addr_d = addr_s0;
      s1_tag_d  = tag_ROB_awake;
    end
  end

  // S1: registered op waiting to enter the FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_tag_q   <= s1_tag_d;
    end
  end

  assign push_entry.addr    = s1_addr_q;
  assign push_entry.tag_ROB = s1_tag_q;

  agu_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .push_i      (s1_valid_q),
    .push_data_i (push_entry),
    .pop_i       (ready_lsu),
    .valid_o     (valid_agu),
    .head_o      (head_entry),
    .count_o     (count_agu)
  );

  assign addr_agu    = head_entry.addr;
  assign tag_ROB_agu = head_entry.tag_ROB;

  // Counts every op already committed to reach the FIFO; a same-cycle pop is deliberately ignored.
  assign occ_sum     = SUM_W'(count_agu) + SUM_W'(s1_valid_q) + SUM_W'(valid_op_awake);
  assign freeze_back = rst && (occ_sum >= SUM_W'(DEPTH));

endmodule

// File: tb/tb_agu_addr_stage.sv
// Self-checking bench for agu_addr_stage: directed scenarios plus random traffic
// against a timestamped queue model of the stage.
module tb_agu_addr_stage;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        valid_op_awake = 1'b0;
  logic [4:0]  Pa_awake = '0;
  logic [4:0]  Imm_awake = '0;
  logic [4:0]  tag_ROB_awake = '0;
  logic [4:0]  rd_addr_prf;
  logic [31:0] rd_data_prf;
  logic        freeze_back;
  logic        valid_agu;
  logic [31:0] addr_agu;
  logic [4:0]  tag_ROB_agu;
  logic        ready_lsu = 1'b0;
  logic [2:0]  count_agu;

  logic [31:0] prf [32];
  assign rd_data_prf = prf[rd_addr_prf];

  agu_addr_stage #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .valid_op_awake (valid_op_awake),
    .Pa_awake       (Pa_awake),
    .Imm_awake      (Imm_awake),
    .tag_ROB_awake  (tag_ROB_awake),
    .rd_addr_prf    (rd_addr_prf),
    .rd_data_prf    (rd_data_prf),
    .freeze_back    (freeze_back),
    .valid_agu      (valid_agu),
    .addr_agu       (addr_agu),
    .tag_ROB_agu    (tag_ROB_agu),
    .ready_lsu      (ready_lsu),
    .count_agu      (count_agu)
  );

  always #5 clk = ~clk;

  // Each accepted op becomes visible at the FIFO head two cycles after issue.
  typedef struct {
    logic [31:0] addr;
    logic [4:0]  tag;
    int          avail;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  logic last_frz = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  task automatic step(input logic v, input logic [4:0] pa, input logic [4:0] imm,
                      input logic [4:0] tag, input logic rdy, input logic fl);
    int   vis;
    logic frz;
    exp_t e;
    valid_op_awake = v;
    Pa_awake       = pa;
    Imm_awake      = imm;
    tag_ROB_awake  = tag;
    ready_lsu      = rdy;
    flush          = fl;
    @(negedge clk);
    vis = 0;
    foreach (q[i]) if (q[i].avail <= cyc) vis++;
    chk("valid", valid_agu, vis > 0);
    chk("addr", addr_agu, (vis > 0) ? q[0].addr : 32'h0);
    chk("tag", tag_ROB_agu, (vis > 0) ? q[0].tag : 5'h0);
    chk("count", count_agu, vis);
    frz = (q.size() + int'(v)) >= DEPTH;
    chk("freeze", freeze_back, frz);
    chk("rd_addr", rd_addr_prf, pa);
    chk("no_push_full", u_dut.u_fifo.push_i && (count_agu == DEPTH) &&
        !(valid_agu && ready_lsu) && !flush, 1'b0);
    last_frz = frz;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (vis > 0 && rdy) void'(q.pop_front());
      if (v) begin
        e.addr  = prf[pa] + {27'b0, imm};
        e.tag   = tag;
        e.avail = cyc + 2;
        q.push_back(e);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 5'd0, 5'd0, 5'd0, rdy, 1'b0);
  endtask

  logic [4:0] tg;
  logic       saw_frz;

  initial begin
    foreach (prf[i]) prf[i] = $urandom;
    prf[0] = 32'h0;
    prf[1] = 32'hFFFF_FFFE;
    prf[3] = 32'h0000_1000;

    #12;
    chk("rst_valid", valid_agu, 1'b0);
    chk("rst_addr", addr_agu, 32'h0);
    chk("rst_tag", tag_ROB_agu, 5'h0);
    chk("rst_count", count_agu, 3'd0);
    chk("rst_freeze", freeze_back, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // single op, two-cycle latency
    step(1'b1, 5'd3, 5'd5, 5'd7, 1'b1, 1'b0);
    idle(1'b1);
    chk("single_valid", valid_agu, 1'b1);
    chk("single_addr", addr_agu, 32'h0000_1005);
    chk("single_tag", tag_ROB_agu, 5'd7);
    idle(1'b1);
    chk("single_gone", valid_agu, 1'b0);

    // address wrap-around
    step(1'b1, 5'd1, 5'd3, 5'd9, 1'b1, 1'b0);
    idle(1'b1);
    chk("wrap_addr", addr_agu, 32'h0000_0001);
    idle(1'b1);
    idle(1'b1);

    // back-pressure: issue every cycle the RS is allowed to
    tg = 5'd0;
    saw_frz = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!last_frz) begin
        step(1'b1, 5'd2, 5'(i), tg, 1'b0, 1'b0);
        tg = tg + 5'd1;
      end else begin
        idle(1'b0);
      end
      if (last_frz) saw_frz = 1'b1;
    end
    chk("bp_saw_freeze", saw_frz, 1'b1);
    chk("bp_count_full", count_agu, 3'd4);
    chk("bp_issued", tg, 5'd4);
    for (int j = 0; j < 4; j++) begin
      chk("drain_tag", tag_ROB_agu, 5'(j));
      idle(1'b1);
    end
    chk("drain_empty", valid_agu, 1'b0);

    // full-ish with simultaneous push and pop
    for (int i = 0; i < 4; i++) step(!last_frz, 5'd3, 5'(i), 5'(10 + i), 1'b0, 1'b0);
    idle(1'b1);
    chk("pp_count", count_agu, 3'd3);
    chk("pp_head", tag_ROB_agu, 5'd11);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // flush with FIFO, S1 and the incoming op all occupied
    for (int i = 0; i < 4; i++) step(1'b1, 5'd3, 5'(i), 5'(16 + i), 1'b0, 1'b0);
    chk("pre_flush_count", count_agu, 3'd3);
    step(1'b1, 5'd3, 5'd1, 5'd21, 1'b0, 1'b1);
    chk("flush_valid", valid_agu, 1'b0);
    chk("flush_count", count_agu, 3'd0);
    step(1'b1, 5'd3, 5'd2, 5'd20, 1'b1, 1'b0);
    chk("post_flush_empty", valid_agu, 1'b0);
    idle(1'b1);
    chk("post_flush_valid", valid_agu, 1'b1);
    chk("post_flush_tag", tag_ROB_agu, 5'd20);
    chk("post_flush_addr", addr_agu, 32'h0000_1002);
    idle(1'b1);

    // asynchronous reset between clock edges with entries queued
    step(1'b1, 5'd3, 5'd1, 5'd1, 1'b0, 1'b0);
    step(1'b1, 5'd3, 5'd2, 5'd2, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("pre_rst_count", count_agu, 3'd2);
    valid_op_awake = 1'b0;
    ready_lsu      = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", valid_agu, 1'b0);
    chk("arst_count", count_agu, 3'd0);
    chk("arst_freeze", freeze_back, 1'b0);
    chk("arst_addr", addr_agu, 32'h0);
    q.delete();
    rst = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    step(1'b1, 5'd0, 5'd31, 5'd3, 1'b1, 1'b0);
    idle(1'b1);
    chk("arst_op_addr", addr_agu, 32'd31);
    chk("arst_op_tag", tag_ROB_agu, 5'd3);
    idle(1'b1);

    // random traffic respecting freeze_back
    for (int i = 0; i < 400; i++) begin
      step(!last_frz && ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    end
    for (int i = 0; i < 8; i++) idle(1'b1);
    chk("final_empty", count_agu, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
